nn_inference_sequencer: RTL and testbench
=========================================

// Module: nn_inference_sequencer
// PURPOSE
//  Sequences one forward pass of the 2-layer MLP (784 -> N_HID ReLU -> 10) over the 28x28 canvas.
//  Issues canvas pixel and weight-ROM addresses, owns the MAC accumulator and the hidden-activation buffer.
//  Publishes the 10 Q8.8 class scores plus the argmax digit.
//  Started by the per-frame Compute strobe (VGA_VS); feeds the probability display/HEX path.
// PARAMETERS
//  N_IN   784    inputs per layer-1 neuron (canvas pixels, row*28+col)
//  N_HID  32     hidden neurons
//  N_OUT  10     output classes
//  DW     16     data width, signed Q8.8 (pixels, weights, activations, scores)
//  ACC_W  40     accumulator width, signed Q16.16
//  WA_W   15     weight ROM address width (>= clog2(N_HID*(N_IN+1)+N_OUT*(N_HID+1)))
// PORTS
//  Clk          in   1           system clock
//  Reset        in   1           asynchronous, active-high reset
//  Compute      in   1           start request; rising edge sampled in Clk domain
//  Busy         out  1           pass in progress
//  Ready        out  1           one-cycle pulse when Probability/Digit updated
//  pix_addr     out  10          canvas pixel index
//  pix_data     in   DW          canvas pixel, combinational from pix_addr
//  w_addr       out  WA_W        weight ROM address
//  w_data       in   DW          weight ROM data, valid 1 cycle after w_addr
//  Probability  out  N_OUT*DW    class k score at [k*DW +: DW]
//  Digit        out  4           argmax class index
// BEHAVIOUR
//  Reset: state IDLE; Busy=0, Ready=0, Probability=0, Digit=4'hF, pix_addr=0, w_addr=0, accumulator=0.
//  Compute is synchronised (2 FFs) and edge-detected. A rising edge in IDLE starts a pass.
//  Edges while Busy are ignored; no queueing. A level held high starts exactly one pass.
//  ROM layout: L1 row j at j*(N_IN+1), bias last. L2 row k at N_HID*(N_IN+1)+k*(N_HID+1), bias last.
//  Bias term multiplies the constant 1.0 (16'h0100).
//  States: IDLE -> L1_MAC -> L1_WB (loop N_HID) -> L2_MAC -> L2_WB (loop N_OUT) -> ARGMAX -> DONE -> IDLE.
//  MAC neuron of F inputs: F issue cycles + 1 drain cycle; acc += a*b, with a 32-bit product sign-extended to ACC_W.
//  Operand alignment: the a operand (pix_data or hidden-buffer read) is registered once to align with w_data.
//  Accumulator is cleared on the first issue cycle of each neuron.
//  Writeback (1 cycle): r = acc >>> 8, saturated to [16'h8000,16'h7FFF].
//  L1 writeback: ReLU (r<0 -> 0), then written to the hidden buffer.
//  L2 writeback: r written to the score staging register.
//  Per neuron: F+2 cycles. L1: N_HID*(N_IN+3). L2: N_OUT*(N_HID+3).
//  ARGMAX: N_OUT cycles, strict '>' scan, so ties resolve to the lowest index.
//  DONE (1 cycle): staging -> Probability and Digit, atomically; Ready=1 for this cycle only; Busy drops next cycle.
//  Latency (defaults, macro on): Ready is 25545 cycles after the cycle the synchronised edge is detected.
//  Probability/Digit hold their last values through a pass. They never show partial results.
//  Reset mid-pass: immediate abort to reset values. The next Compute edge runs a full pass.
// CONFIGURATION
//  NN_SEQ_ARGMAX_EN defined: ARGMAX state present, Digit = argmax as above.
//  NN_SEQ_ARGMAX_EN undefined: ARGMAX state skipped (L2_WB -> DONE), Digit tied 4'hF.
//  Without the macro, latency drops by N_OUT cycles (25535).
// STRUCTURE
//  Package nn_pkg holds:
//   - state enum nn_seq_state_t
//   - Q8.8 constants ONE_Q=16'h0100, Q_MAX, Q_MIN
//   - function sat_q88(acc) for shift+saturate
//   - canvas geometry constants (28, 784)
//  Sub-module nn_hidden_buf: N_HID x DW register file, 1 sync write port, 1 combinational read port, cleared on Reset.
// TESTING
//  1 All pixels 0, L1 biases 0x0100, L2 row 7 weights 0x0100 (others 0), L2 biases 0
//    -> Probability[7]=0x2000, others 0, Digit=7; Ready at cycle 25545.
//  2 L1 biases 0xFF00 (-1.0), L2 biases 0x0280
//    -> ReLU zeroes all hidden; every score 0x0280; Digit=0 (tie -> lowest index).
//  3 All pixels 0x7FFF, all L1 weights 0x7FFF
//    -> hidden saturate to 0x7FFF (no wrap).
//  3b All pixels 0x7FFF, L1 weights 0x8000
//    -> hidden 0 after ReLU.
//  4 Compute held high 30000 cycles, plus an extra pulse at cycle 100
//    -> exactly one Ready pulse, Busy continuous.
//  5 Reset asserted at cycle 5000 of a pass
//    -> Busy=0, Probability=0, Digit=F same cycle.
//    -> A following Compute edge gives a full-length pass with correct scores.
//  6 Macro undefined, stimulus of test 1
//    -> Ready at cycle 25535, Digit=4'hF, Probability unchanged vs test 1.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and Q8.8 helpers for the MLP inference sequencer.
package nn_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_L1_MAC,
      S_L1_WB,
      S_L2_MAC,
      S_L2_WB,
      S_ARGMAX,
      S_DONE
   } nn_seq_state_t;

   localparam logic [15:0] ONE_Q = 16'h0100;
   localparam logic [15:0] Q_MAX = 16'h7FFF;
   localparam logic [15:0] Q_MIN = 16'h8000;

   localparam int CANVAS_W   = 28;
   localparam int CANVAS_PIX = CANVAS_W * CANVAS_W;

   // Q16.16 accumulator back to Q8.8, clamped instead of wrapped
   function automatic logic [15:0] sat_q88(input logic signed [63:0] acc);
      logic signed [63:0] r;
      r = acc >>> 8;
      if (r > 64'sd32767) return Q_MAX;
      if (r < -64'sd32768) return Q_MIN;
      return r[15:0];
   endfunction

endpackage

// File: rtl/nn_inference_sequencer_if.sv
// Control, memory-address and result bundle between the sequencer and its canvas/ROM/display.
interface nn_inference_sequencer_if #(
   parameter int DW    = 16,
   parameter int N_OUT = 10,
   parameter int WA_W  = 15
);
   logic                compute;
   logic                busy;
   logic                ready;
   logic [9:0]          pix_addr;
   logic [DW-1:0]       pix_data;
   logic [WA_W-1:0]     w_addr;
   logic [DW-1:0]       w_data;
   logic [N_OUT*DW-1:0] probability;
   logic [3:0]          digit;

   modport master (
      input  compute, pix_data, w_data,
      output busy, ready, pix_addr, w_addr, probability, digit
   );

   modport slave (
      output compute, pix_data, w_data,
      input  busy, ready, pix_addr, w_addr, probability, digit
   );
endinterface

// File: rtl/nn_hidden_buf.sv
// Hidden-activation register file: one synchronous write port, one combinational read port.
module nn_hidden_buf #(
   parameter int N_HID = 32,
   parameter int DW    = 16,
   localparam int HA_W = (N_HID > 1) ? $clog2(N_HID) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [HA_W-1:0] wr_addr,
   input  logic [DW-1:0]   wr_data,
   input  logic [HA_W-1:0] rd_addr,
   output logic [DW-1:0]   rd_data
);
   logic [DW-1:0] mem [N_HID];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N_HID; k++) mem[k] <= '0;
      end else if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];
endmodule

// File: rtl/nn_inference_sequencer.sv
// Forward-pass sequencer for the canvas MLP: addresses pixels/weights, MACs, ReLU, publishes scores.
// Optional argmax stage enabled by defining NN_SEQ_ARGMAX_EN; without it digit is tied to 4'hF.
module nn_inference_sequencer
   import nn_pkg::*;
#(
   parameter int N_IN  = CANVAS_PIX,
   parameter int N_HID = 32,
   parameter int N_OUT = 10,
   parameter int DW    = 16,
   parameter int ACC_W = 40,
   parameter int WA_W  = 15
) (
   input logic clk,
   input logic rst,
   nn_inference_sequencer_if.master bus
);
   localparam int IDX_W   = $clog2(N_IN + 2);
   localparam int NEU_MAX = (N_HID > N_OUT) ? N_HID : N_OUT;
   localparam int NEU_W   = $clog2(NEU_MAX + 1);
   localparam int HA_W    = (N_HID > 1) ? $clog2(N_HID) : 1;
   localparam int OUT_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam logic [IDX_W-1:0] F1       = IDX_W'(N_IN + 1);
   localparam logic [IDX_W-1:0] F2       = IDX_W'(N_HID + 1);
   localparam logic [IDX_W-1:0] N_IN_I   = IDX_W'(N_IN);
   localparam logic [IDX_W-1:0] N_HID_I  = IDX_W'(N_HID);
   localparam logic [NEU_W-1:0] HID_LAST = NEU_W'(N_HID - 1);
   localparam logic [NEU_W-1:0] OUT_LAST = NEU_W'(N_OUT - 1);

   nn_seq_state_t state, state_next;
   logic c_meta, c_sync, c_prev, start_edge;
   logic [IDX_W-1:0] idx, f_cur;
   logic [NEU_W-1:0] neuron;
   logic in_mac, issue;
   logic signed [DW-1:0] a_sel, a_reg;
   logic signed [2*DW-1:0] prod;
   logic signed [ACC_W-1:0] acc;
   logic [DW-1:0] hid_rd, wb_val, relu_val;
   logic signed [DW-1:0] staging [N_OUT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_meta <= 1'b0;
         c_sync <= 1'b0;
         c_prev <= 1'b0;
      end else begin
         c_meta <= bus.compute;
         c_sync <= c_meta;
         c_prev <= c_sync;
      end
   end

   assign start_edge = c_sync & ~c_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // The MAC states stay put for F issue cycles plus one drain cycle (idx == F)
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (start_edge) state_next = S_L1_MAC;
         S_L1_MAC: if (idx == F1) state_next = S_L1_WB;
         S_L1_WB:  state_next = (neuron == HID_LAST) ? S_L2_MAC : S_L1_MAC;
         S_L2_MAC: if (idx == F2) state_next = S_L2_WB;
`ifdef NN_SEQ_ARGMAX_EN
         S_L2_WB:  state_next = (neuron == OUT_LAST) ? S_ARGMAX : S_L2_MAC;
         S_ARGMAX: if (neuron == OUT_LAST) state_next = S_DONE;
`else
         S_L2_WB:  state_next = (neuron == OUT_LAST) ? S_DONE : S_L2_MAC;
`endif
         S_DONE:   state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   assign in_mac = (state == S_L1_MAC) || (state == S_L2_MAC);
   assign f_cur  = (state == S_L2_MAC) ? F2 : F1;
   assign issue  = in_mac && (idx < f_cur);

   always_comb begin
      a_sel = DW'(ONE_Q);
      if (state == S_L1_MAC && idx < N_IN_I)
         a_sel = bus.pix_data;
      else if (state == S_L2_MAC && idx < N_HID_I)
         a_sel = hid_rd;
   end

   assign prod     = a_reg * $signed(bus.w_data);
   assign wb_val   = sat_q88(64'(acc));
   assign relu_val = wb_val[DW-1] ? '0 : wb_val;
   assign bus.busy  = (state != S_IDLE);
   assign bus.ready = (state == S_DONE);

`ifdef NN_SEQ_ARGMAX_EN
   logic signed [DW-1:0] best;
   logic [3:0] best_idx, digit_q;
   logic arg_better;
   assign arg_better = (neuron == '0) || (staging[neuron[OUT_W-1:0]] > best);
   assign bus.digit  = digit_q;
`else
   assign bus.digit = 4'hF;
`endif

   // Results are loaded on the edge into DONE so they are valid while ready is high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx             <= '0;
         neuron          <= '0;
         a_reg           <= '0;
         acc             <= '0;
         bus.pix_addr    <= '0;
         bus.w_addr      <= '0;
         bus.probability <= '0;
         for (int k = 0; k < N_OUT; k++) staging[k] <= '0;
`ifdef NN_SEQ_ARGMAX_EN
         best     <= '0;
         best_idx <= '0;
         digit_q  <= 4'hF;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               idx          <= '0;
               neuron       <= '0;
               bus.pix_addr <= '0;
               bus.w_addr   <= '0;
            end
            S_L1_MAC, S_L2_MAC: begin
               if (issue) begin
                  a_reg      <= a_sel;
                  bus.w_addr <= bus.w_addr + 1'b1;
                  if (state == S_L1_MAC)
                     bus.pix_addr <= (idx + 1'b1 < N_IN_I) ? bus.pix_addr + 10'd1 : '0;
               end
               acc <= (idx == '0) ? '0 : acc + ACC_W'(prod);
               idx <= idx + 1'b1;
            end
            S_L1_WB: begin
               idx    <= '0;
               neuron <= (neuron == HID_LAST) ? '0 : neuron + 1'b1;
            end
            S_L2_WB: begin
               idx    <= '0;
               neuron <= (neuron == OUT_LAST) ? '0 : neuron + 1'b1;
               staging[neuron[OUT_W-1:0]] <= wb_val;
`ifndef NN_SEQ_ARGMAX_EN
               if (neuron == OUT_LAST)
                  for (int k = 0; k < N_OUT; k++)
                     bus.probability[k*DW +: DW] <= (k == int'(neuron)) ? wb_val : staging[k];
`endif
            end
`ifdef NN_SEQ_ARGMAX_EN
            S_ARGMAX: begin
               neuron <= (neuron == OUT_LAST) ? '0 : neuron + 1'b1;
               if (arg_better) begin
                  best     <= staging[neuron[OUT_W-1:0]];
                  best_idx <= 4'(neuron);
               end
               if (neuron == OUT_LAST) begin
                  for (int k = 0; k < N_OUT; k++) bus.probability[k*DW +: DW] <= staging[k];
                  digit_q <= arg_better ? 4'(neuron) : best_idx;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   nn_hidden_buf #(.N_HID(N_HID), .DW(DW)) u_hid (
      .clk     (clk),
      .rst     (rst),
      .we      (state == S_L1_WB),
      .wr_addr (neuron[HA_W-1:0]),
      .wr_data (relu_val),
      .rd_addr (idx[HA_W-1:0]),
      .rd_data (hid_rd)
   );
endmodule

// File: tb/tb_nn_inference_sequencer.sv
// Bench for nn_inference_sequencer: a reduced-size instance against an arithmetic MLP model,
// plus a default-size instance for the full-length pass. Honours NN_SEQ_ARGMAX_EN.
module tb_nn_inference_sequencer;
   localparam int S_IN  = 16;
   localparam int S_HID = 4;
   localparam int S_OUT = 10;
   localparam int S_ROM = S_HID*(S_IN+1) + S_OUT*(S_HID+1);
`ifdef NN_SEQ_ARGMAX_EN
   localparam bit ARGMAX_ON = 1'b1;
`else
   localparam bit ARGMAX_ON = 1'b0;
`endif
   localparam int S_LAT = S_HID*(S_IN+3) + S_OUT*(S_HID+3) + (ARGMAX_ON ? S_OUT : 0) + 1;
   localparam int F_LAT = ARGMAX_ON ? 25545 : 25535;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   nn_inference_sequencer_if #(.DW(16), .N_OUT(10), .WA_W(15)) sbus ();
   nn_inference_sequencer_if #(.DW(16), .N_OUT(10), .WA_W(15)) fbus ();

   nn_inference_sequencer #(.N_IN(S_IN), .N_HID(S_HID), .N_OUT(S_OUT), .DW(16), .ACC_W(40), .WA_W(15))
      dut (.clk(clk), .rst(rst), .bus(sbus));
   nn_inference_sequencer dut_full (.clk(clk), .rst(rst), .bus(fbus));

   logic [15:0] pix_mem [S_IN];
   logic [15:0] w_mem [S_ROM];
   logic [15:0] exp_score [S_OUT];
   logic [3:0]  exp_digit;

   // Canvas is combinational, weight ROM has one cycle of latency
   assign sbus.pix_data = (sbus.pix_addr < 10'(S_IN)) ? pix_mem[sbus.pix_addr[3:0]] : 16'h0000;
   always @(posedge clk) sbus.w_data <= (int'(sbus.w_addr) < S_ROM) ? w_mem[sbus.w_addr[6:0]] : 16'h0000;

   function automatic logic [15:0] full_rom(input int a);
      int o;
      if (a < 32*785) return (a % 785 == 784) ? 16'h0100 : 16'h0000;
      o = a - 32*785;
      if (o / 33 == 7 && o % 33 < 32) return 16'h0100;
      return 16'h0000;
   endfunction

   assign fbus.pix_data = 16'h0000;
   always @(posedge clk) fbus.w_data <= full_rom(int'(fbus.w_addr));

   function automatic int l1a(input int j, input int i);
      return j*(S_IN+1) + i;
   endfunction

   function automatic int l2a(input int k, input int i);
      return S_HID*(S_IN+1) + k*(S_HID+1) + i;
   endfunction

   function automatic logic [15:0] sat16(input longint acc);
      longint r;
      r = acc >>> 8;
      if (r > 32767) return 16'h7FFF;
      if (r < -32768) return 16'h8000;
      return r[15:0];
   endfunction

   // Reference forward pass with plain integer arithmetic
   task automatic model_pass();
      longint acc;
      logic [15:0] hid [S_HID];
      logic [15:0] r;
      int bi;
      for (int j = 0; j < S_HID; j++) begin
         acc = 0;
         for (int i = 0; i < S_IN; i++)
            acc += longint'($signed(pix_mem[i])) * longint'($signed(w_mem[l1a(j, i)]));
         acc += 256 * longint'($signed(w_mem[l1a(j, S_IN)]));
         r = sat16(acc);
         hid[j] = r[15] ? 16'h0000 : r;
      end
      for (int k = 0; k < S_OUT; k++) begin
         acc = 0;
         for (int i = 0; i < S_HID; i++)
            acc += longint'($signed(hid[i])) * longint'($signed(w_mem[l2a(k, i)]));
         acc += 256 * longint'($signed(w_mem[l2a(k, S_HID)]));
         exp_score[k] = sat16(acc);
      end
      bi = 0;
      for (int k = 1; k < S_OUT; k++)
         if ($signed(exp_score[k]) > $signed(exp_score[bi])) bi = k;
      exp_digit = ARGMAX_ON ? 4'(bi) : 4'hF;
   endtask

   task automatic fill_random();
      int v;
      for (int i = 0; i < S_IN; i++) pix_mem[i] = 16'($urandom_range(0, 256));
      for (int a = 0; a < S_ROM; a++) begin
         v = int'($urandom_range(0, 1023)) - 512;
         w_mem[a] = 16'(v);
      end
   endtask

   task automatic run_small_pass(input string name);
      logic [159:0] prev;
      int c0, t_ready;
      bit seen;
      model_pass();
      repeat (4) @(negedge clk);
      prev = sbus.probability;
      sbus.compute = 1'b1;
      c0 = cyc;
      repeat (2) @(negedge clk);
      sbus.compute = 1'b0;
      seen = 1'b0;
      t_ready = 0;
      for (int i = 0; i < S_LAT + 50 && !seen; i++) begin
         @(negedge clk);
         if (cyc == c0 + S_LAT/2) begin
            n_tests++;
            if (sbus.probability !== prev) begin
               n_fail++;
               $display("[TB] FAIL %s hold: probability %h changed mid-pass, required %h", name, sbus.probability, prev);
            end
         end
         if (sbus.ready === 1'b1) begin
            seen = 1'b1;
            t_ready = cyc;
         end
      end
      n_tests++;
      if (!seen) begin
         n_fail++;
         $display("[TB] FAIL %s ready: no ready pulse within %0d cycles", name, S_LAT + 50);
         return;
      end
      if (t_ready - c0 !== S_LAT + 2) begin
         n_fail++;
         $display("[TB] FAIL %s latency: got %0d required %0d", name, t_ready - c0, S_LAT + 2);
      end
      for (int k = 0; k < S_OUT; k++) begin
         n_tests++;
         if (sbus.probability[k*16 +: 16] !== exp_score[k]) begin
            n_fail++;
            $display("[TB] FAIL %s score[%0d]: got %h required %h", name, k, sbus.probability[k*16 +: 16], exp_score[k]);
         end
      end
      n_tests++;
      if (sbus.digit !== exp_digit) begin
         n_fail++;
         $display("[TB] FAIL %s digit: got %h required %h", name, sbus.digit, exp_digit);
      end
      @(negedge clk);
      n_tests++;
      if (sbus.ready !== 1'b0 || sbus.busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL %s after_done: ready=%b busy=%b required 0 0", name, sbus.ready, sbus.busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      sbus.compute = 1'b0;
      fbus.compute = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (sbus.busy !== 1'b0 || sbus.ready !== 1'b0 || sbus.probability !== '0 || sbus.digit !== 4'hF
          || sbus.pix_addr !== 10'd0 || sbus.w_addr !== 15'd0) begin
         n_fail++;
         $display("[TB] FAIL reset: busy=%b ready=%b prob=%h digit=%h pix=%h w=%h required 0 0 0 f 0 0",
                  sbus.busy, sbus.ready, sbus.probability, sbus.digit, sbus.pix_addr, sbus.w_addr);
      end
      rst = 1'b0;
   endtask

   task automatic test_full_size();
      int c0, t_ready;
      bit seen;
      logic [15:0] want;
      repeat (4) @(negedge clk);
      fbus.compute = 1'b1;
      c0 = cyc;
      repeat (2) @(negedge clk);
      fbus.compute = 1'b0;
      seen = 1'b0;
      t_ready = 0;
      for (int i = 0; i < F_LAT + 50 && !seen; i++) begin
         @(negedge clk);
         if (cyc == c0 + F_LAT/2) begin
            n_tests++;
            if (fbus.probability !== '0 || fbus.digit !== 4'hF) begin
               n_fail++;
               $display("[TB] FAIL full hold: prob=%h digit=%h required 0 f", fbus.probability, fbus.digit);
            end
         end
         if (fbus.ready === 1'b1) begin
            seen = 1'b1;
            t_ready = cyc;
         end
      end
      n_tests++;
      if (!seen) begin
         n_fail++;
         $display("[TB] FAIL full ready: no ready pulse within %0d cycles", F_LAT + 50);
         return;
      end
      if (t_ready - c0 !== F_LAT + 2) begin
         n_fail++;
         $display("[TB] FAIL full latency: got %0d required %0d", t_ready - c0, F_LAT + 2);
      end
      for (int k = 0; k < 10; k++) begin
         want = (k == 7) ? 16'h2000 : 16'h0000;
         n_tests++;
         if (fbus.probability[k*16 +: 16] !== want) begin
            n_fail++;
            $display("[TB] FAIL full score[%0d]: got %h required %h", k, fbus.probability[k*16 +: 16], want);
         end
      end
      n_tests++;
      if (fbus.digit !== (ARGMAX_ON ? 4'd7 : 4'hF)) begin
         n_fail++;
         $display("[TB] FAIL full digit: got %h required %h", fbus.digit, ARGMAX_ON ? 4'd7 : 4'hF);
      end
   endtask

   task automatic test_random_passes();
      for (int p = 0; p < 3; p++) begin
         fill_random();
         run_small_pass($sformatf("random%0d", p));
      end
   endtask

   task automatic test_relu_tie();
      fill_random();
      for (int i = 0; i < S_IN; i++) pix_mem[i] = 16'h0000;
      for (int j = 0; j < S_HID; j++) w_mem[l1a(j, S_IN)] = 16'hFF00;
      for (int k = 0; k < S_OUT; k++) w_mem[l2a(k, S_HID)] = 16'h0280;
      run_small_pass("relu_tie");
   endtask

   task automatic test_saturation();
      for (int i = 0; i < S_IN; i++) pix_mem[i] = 16'h7FFF;
      for (int a = 0; a < S_HID*(S_IN+1); a++) w_mem[a] = 16'h7FFF;
      for (int k = 0; k < S_OUT; k++)
         for (int i = 0; i <= S_HID; i++)
            w_mem[l2a(k, i)] = (i == k % S_HID) ? 16'h0100 : 16'h0000;
      run_small_pass("sat_pos");
      for (int a = 0; a < S_HID*(S_IN+1); a++) w_mem[a] = 16'h8000;
      for (int k = 0; k < S_OUT; k++) w_mem[l2a(k, S_HID)] = 16'($urandom_range(0, 16'hFFFF));
      run_small_pass("sat_neg");
   endtask

   task automatic test_held_compute();
      int readies, gap, after;
      bit started;
      readies = 0;
      gap = 0;
      after = 0;
      started = 1'b0;
      repeat (4) @(negedge clk);
      sbus.compute = 1'b1;
      for (int i = 0; i < 2*S_LAT + 60; i++) begin
         @(negedge clk);
         if (i == 30) sbus.compute = 1'b0;
         else if (i == 31) sbus.compute = 1'b1;
         if (sbus.busy === 1'b1) started = 1'b1;
         if (readies > 0 && sbus.busy === 1'b1) after++;
         if (started && sbus.busy !== 1'b1 && readies == 0) gap++;
         if (sbus.ready === 1'b1) readies++;
      end
      sbus.compute = 1'b0;
      n_tests++;
      if (readies !== 1) begin
         n_fail++;
         $display("[TB] FAIL held ready_count: got %0d required 1", readies);
      end
      n_tests++;
      if (gap !== 0 || after !== 0) begin
         n_fail++;
         $display("[TB] FAIL held busy: gap=%0d busy_after=%0d required 0 0", gap, after);
      end
   endtask

   task automatic test_reset_mid_pass();
      fill_random();
      repeat (4) @(negedge clk);
      sbus.compute = 1'b1;
      repeat (2) @(negedge clk);
      sbus.compute = 1'b0;
      repeat (40) @(negedge clk);
      n_tests++;
      if (sbus.busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL abort pre: busy=%b required 1", sbus.busy);
      end
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if (sbus.busy !== 1'b0 || sbus.ready !== 1'b0 || sbus.probability !== '0 || sbus.digit !== 4'hF) begin
         n_fail++;
         $display("[TB] FAIL abort: busy=%b ready=%b prob=%h digit=%h required 0 0 0 f",
                  sbus.busy, sbus.ready, sbus.probability, sbus.digit);
      end
      @(negedge clk);
      rst = 1'b0;
      fill_random();
      run_small_pass("after_abort");
   endtask

   initial begin
      sbus.compute = 1'b0;
      fbus.compute = 1'b0;
      rst = 1'b1;
      test_reset();
      test_full_size();
      test_random_passes();
      test_relu_tie();
      test_saturation();
      test_held_compute();
      test_reset_mid_pass();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
